// File: rtl/mem_seq.sv
// mem_seq -- byte-serial memory sequencer shared by an instruction-fetch
// port and a load/store port, driving an 8-bit synchronous-read RAM.
//
// Each accepted request is split into 1, 2 or 4 single-byte RAM accesses on
// consecutive addresses (wrapping modulo 2^32).  Reads are reassembled
// little-endian into rdata.  Completion is signalled by a one-cycle
// if_done or mem_done pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   if_req/if_addr  4-byte instruction fetch request and byte address
//   mem_req         00 none, 01 load, 10 store, 11 ignored
//   mem_addr        load/store byte address
//   mem_size        00 1 byte, 01 2 bytes, 10/11 4 bytes
//   mem_wdata       store data, byte i = bits [8i+7:8i]
//   if_done         completion pulse for the fetch port
//   mem_done        completion pulse for the load/store port
//   rdata           read data, valid only during a done pulse
//   busy            high whenever the sequencer is not idle
//   ram_din         RAM read byte, valid one cycle after its address
//   ram_addr        RAM byte address
//   ram_dout        RAM write byte
//   ram_rw          RAM direction, 0 read, 1 write
//
// Build option: define MEM_SEQ_FAIR_EN to replace the fixed MEM-over-IF
// tie-break with round-robin (the requester not granted last wins a tie).
module mem_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic [1:0]  mem_req,
   input  logic [31:0] mem_addr,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_wdata,
   input  logic [7:0]  ram_din,
   output logic        if_done,
   output logic        mem_done,
   output logic [31:0] rdata,
   output logic        busy,
   output logic [31:0] ram_addr,
   output logic [7:0]  ram_dout,
   output logic        ram_rw
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;      // cycle index inside RD/WR
   logic [2:0]  len_q, len_d;      // byte count of the transfer
   logic        gnt_if_q, gnt_if_d;
   logic        wr_q, wr_d;
   logic [31:0] base_q, base_d;
   logic [31:0] data_q, data_d;    // write data, or read assembly buffer

   logic        mem_vld;
   logic        pick_mem;
   logic [1:0]  cap_idx;

   function automatic logic [2:0] size_len(input logic [1:0] size);
      case (size)
         2'b00:   size_len = 3'd1;
         2'b01:   size_len = 3'd2;
         default: size_len = 3'd4;
      endcase
   endfunction

   assign mem_vld = (mem_req == 2'b01) || (mem_req == 2'b10);

`ifdef MEM_SEQ_FAIR_EN
   logic last_if_q, last_if_d;

   // On a tie, MEM wins only if IF was the last one granted.
   assign pick_mem = mem_vld && (!if_req || last_if_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_if_q <= 1'b1;
      else     last_if_q <= last_if_d;
   end

   always_comb begin
      last_if_d = last_if_q;
      if (state_q == IDLE && (mem_vld || if_req)) last_if_d = !pick_mem;
   end
`else
   assign pick_mem = mem_vld;
`endif

   // Byte captured in cycle cnt belongs to the address issued at cnt-1;
   // at cnt=4 the 2-bit wrap yields index 3.
   assign cap_idx = cnt_q[1:0] - 2'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      gnt_if_d = gnt_if_q;
      wr_d     = wr_q;
      base_d   = base_q;
      data_d   = data_q;
      if_done  = 1'b0;
      mem_done = 1'b0;
      rdata    = 32'd0;
      busy     = 1'b0;
      ram_addr = 32'd0;
      ram_dout = 8'd0;
      ram_rw   = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_vld || if_req) begin
               cnt_d    = 3'd0;
               gnt_if_d = !pick_mem;
               if (pick_mem) begin
                  base_d  = mem_addr;
                  len_d   = size_len(mem_size);
                  wr_d    = (mem_req == 2'b10);
                  data_d  = (mem_req == 2'b10) ? mem_wdata : 32'd0;
                  state_d = (mem_req == 2'b10) ? WR : RD;
               end else begin
                  base_d  = if_addr;
                  len_d   = 3'd4;
                  wr_d    = 1'b0;
                  data_d  = 32'd0;
                  state_d = RD;
               end
            end
         end

         RD: begin
            busy = 1'b1;
            if (cnt_q < len_q) ram_addr = base_q + {29'd0, cnt_q};
            if (cnt_q != 3'd0) data_d[{cap_idx, 3'b000} +: 8] = ram_din;
            if (cnt_q == len_q) state_d = DONE;
            else                cnt_d   = cnt_q + 3'd1;
         end

         WR: begin
            busy     = 1'b1;
            ram_rw   = 1'b1;
            ram_addr = base_q + {29'd0, cnt_q};
            ram_dout = data_q[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q == len_q - 3'd1) state_d = DONE;
            else                       cnt_d   = cnt_q + 3'd1;
         end

         DONE: begin
            busy     = 1'b1;
            if_done  = gnt_if_q;
            mem_done = !gnt_if_q;
            rdata    = wr_q ? 32'd0 : data_q;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         len_q    <= 3'd0;
         gnt_if_q <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         gnt_if_q <= gnt_if_d;
         wr_q     <= wr_d;
      end
   end

   // Datapath registers: every use is gated by the state, so no reset needed.
   always_ff @(posedge clk) begin
      base_q <= base_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_mem_seq.sv
module tb_mem_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [1:0]  mem_req;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic [31:0] mem_wdata;
   logic [7:0]  ram_din;
   logic        if_done;
   logic        mem_done;
   logic [31:0] rdata;
   logic        busy;
   logic [31:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_rw;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] mem_arr [0:255];

   mem_seq dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_size  (mem_size),
      .mem_wdata (mem_wdata),
      .ram_din   (ram_din),
      .if_done   (if_done),
      .mem_done  (mem_done),
      .rdata     (rdata),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_dout  (ram_dout),
      .ram_rw    (ram_rw)
   );

   always #5 clk = ~clk;

   // 256-byte RAM model aliased on the low address byte, synchronous read.
   always @(posedge clk) begin
      if (ram_rw) mem_arr[ram_addr[7:0]] <= ram_dout;
      ram_din <= mem_arr[ram_addr[7:0]];
   end

   // Waits for a done pulse; k=1 is the first negedge after the call.
   task automatic wait_done(output int cyc, output logic was_if, output logic [31:0] rd);
      cyc = -1; was_if = 1'b0; rd = 32'd0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (if_done || mem_done) begin
            cyc = k; was_if = if_done; rd = rdata;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; mem_req = 2'b01;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_chk++;
         if ({busy, if_done, mem_done, ram_rw} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 0000", {busy, if_done, mem_done, ram_rw});
         end
         n_chk++;
         if ({rdata, ram_addr, ram_dout} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected 0", {rdata, ram_addr, ram_dout});
         end
      end
      if_req = 1'b0; mem_req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_if_read();
      logic [31:0] exp_a;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0000_1000;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) begin
            exp_a = 32'h0000_1000 + 32'(k - 1);
            n_chk++;
            if (ram_addr !== exp_a || ram_rw !== 1'b0 || busy !== 1'b1 || if_done !== 1'b0) begin
               n_fail++;
               $display("FAIL if_read_addr c%0d: got addr=%h rw=%b busy=%b done=%b, expected addr=%h rw=0 busy=1 done=0",
                        k, ram_addr, ram_rw, busy, if_done, exp_a);
            end
         end else if (k == 5) begin
            n_chk++;
            if (ram_addr !== 32'd0 || busy !== 1'b1 || if_done !== 1'b0) begin
               n_fail++;
               $display("FAIL if_read_gap: got addr=%h busy=%b done=%b, expected addr=0 busy=1 done=0",
                        ram_addr, busy, if_done);
            end
         end else begin
            n_chk++;
            if (if_done !== 1'b1 || mem_done !== 1'b0 || rdata !== 32'h0010_0513) begin
               n_fail++;
               $display("FAIL if_read_done: got if_done=%b mem_done=%b rdata=%h, expected 1 0 00100513",
                        if_done, mem_done, rdata);
            end
            if_req = 1'b0;
         end
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || if_done !== 1'b0) begin
         n_fail++;
         $display("FAIL if_read_idle: got busy=%b if_done=%b, expected 0 0", busy, if_done);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      mem_req = 2'b10; mem_size = 2'b01; mem_addr = 32'h20; mem_wdata = 32'hAABB_CCDD;
      @(negedge clk);
      n_chk++;
      if (ram_rw !== 1'b1 || ram_addr !== 32'h20 || ram_dout !== 8'hDD || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL store_b0: got rw=%b addr=%h dout=%h busy=%b, expected 1 00000020 dd 1",
                  ram_rw, ram_addr, ram_dout, busy);
      end
      // Dropping the request and changing its data must not disturb the store.
      mem_req = 2'b00; mem_wdata = 32'h0;
      @(negedge clk);
      n_chk++;
      if (ram_rw !== 1'b1 || ram_addr !== 32'h21 || ram_dout !== 8'hCC) begin
         n_fail++;
         $display("FAIL store_b1: got rw=%b addr=%h dout=%h, expected 1 00000021 cc",
                  ram_rw, ram_addr, ram_dout);
      end
      @(negedge clk);
      n_chk++;
      if (mem_done !== 1'b1 || if_done !== 1'b0 || rdata !== 32'd0 || ram_rw !== 1'b0 || ram_addr !== 32'd0) begin
         n_fail++;
         $display("FAIL store_done: got mem_done=%b if_done=%b rdata=%h rw=%b addr=%h, expected 1 0 0 0 0",
                  mem_done, if_done, rdata, ram_rw, ram_addr);
      end
      @(negedge clk);
      n_chk++;
      if (mem_arr[8'h20] !== 8'hDD || mem_arr[8'h21] !== 8'hCC || mem_arr[8'h22] !== 8'h5A || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL store_ram: got %h %h %h busy=%b, expected dd cc 5a 0",
                  mem_arr[8'h20], mem_arr[8'h21], mem_arr[8'h22], busy);
      end
   endtask

   task automatic test_priority();
      int          c;
      logic        wi;
      logic [31:0] rd;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h1000;
      mem_req = 2'b01; mem_size = 2'b00; mem_addr = 32'h2;
`ifndef MEM_SEQ_FAIR_EN
      wait_done(c, wi, rd);
      n_chk++;
      if (c != 3 || wi !== 1'b0 || rd !== 32'h10) begin
         n_fail++;
         $display("FAIL prio_first: got cycle=%0d if=%b rdata=%h, expected 3 0 00000010", c, wi, rd);
      end
      mem_req = 2'b00;
      // One idle accept cycle precedes the fetch: done lands 7 negedges later.
      wait_done(c, wi, rd);
      n_chk++;
      if (c != 7 || wi !== 1'b1 || rd !== 32'h0010_0513) begin
         n_fail++;
         $display("FAIL prio_second: got cycle=%0d if=%b rdata=%h, expected 7 1 00100513", c, wi, rd);
      end
      if_req = 1'b0;
`else
      wait_done(c, wi, rd);
      n_chk++;
      if (c != 6 || wi !== 1'b1 || rd !== 32'h0010_0513) begin
         n_fail++;
         $display("FAIL prio_first: got cycle=%0d if=%b rdata=%h, expected 6 1 00100513", c, wi, rd);
      end
      if_req = 1'b0;
      wait_done(c, wi, rd);
      n_chk++;
      if (c != 4 || wi !== 1'b0 || rd !== 32'h10) begin
         n_fail++;
         $display("FAIL prio_second: got cycle=%0d if=%b rdata=%h, expected 4 0 00000010", c, wi, rd);
      end
      mem_req = 2'b00;
`endif
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_idle: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [4];
      exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
      @(negedge clk);
      mem_req = 2'b01; mem_size = 2'b00; mem_addr = 32'hFFFF_FFFF;
      @(negedge clk);
      n_chk++;
      if (ram_addr !== 32'hFFFF_FFFF || ram_rw !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_load_addr: got %h rw=%b, expected ffffffff 0", ram_addr, ram_rw);
      end
      mem_req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (mem_done !== 1'b1 || rdata !== 32'h0000_00EE) begin
         n_fail++;
         $display("FAIL wrap_load_data: got done=%b rdata=%h, expected 1 000000ee", mem_done, rdata);
      end
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) begin
            n_chk++;
            if (ram_addr !== exp_a[k-1]) begin
               n_fail++;
               $display("FAIL wrap_if_addr c%0d: got %h, expected %h", k, ram_addr, exp_a[k-1]);
            end
            if (k == 2) if_addr = 32'h1234_5678;
         end else if (k == 6) begin
            n_chk++;
            if (if_done !== 1'b1 || rdata !== 32'h0513_EEDC) begin
               n_fail++;
               $display("FAIL wrap_if_data: got done=%b rdata=%h, expected 1 0513eedc", if_done, rdata);
            end
            if_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      int          c;
      logic        wi;
      logic [31:0] rd;
      logic        seen;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h1000;
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (ram_addr !== 32'h1001 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_pre: got addr=%h busy=%b, expected 00001001 1", ram_addr, busy);
      end
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if ({busy, if_done, mem_done, ram_rw, ram_addr, ram_dout, rdata} !== 76'd0) begin
         n_fail++;
         $display("FAIL rmid_async: got busy=%b addr=%h rw=%b, expected all zero", busy, ram_addr, ram_rw);
      end
      if_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (if_done || mem_done || busy) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_no_done: got activity=%b, expected 0", seen);
      end
      if_req = 1'b1; if_addr = 32'h1000;
      wait_done(c, wi, rd);
      n_chk++;
      if (c != 6 || wi !== 1'b1 || rd !== 32'h0010_0513) begin
         n_fail++;
         $display("FAIL rmid_after: got cycle=%0d if=%b rdata=%h, expected 6 1 00100513", c, wi, rd);
      end
      if_req = 1'b0;
   endtask

   task automatic test_ignored();
      @(negedge clk);
      mem_req = 2'b11; mem_addr = 32'h40; mem_size = 2'b10;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_chk++;
         if (busy !== 1'b0 || mem_done !== 1'b0 || ram_rw !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_req c%0d: got busy=%b done=%b rw=%b, expected 0 0 0",
                     k, busy, mem_done, ram_rw);
         end
      end
      mem_req = 2'b00;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 2'b00;
      mem_addr = 32'd0; mem_size = 2'b00; mem_wdata = 32'd0;
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'hA5;
      mem_arr[8'h00] = 8'h13; mem_arr[8'h01] = 8'h05;
      mem_arr[8'h02] = 8'h10; mem_arr[8'h03] = 8'h00;
      mem_arr[8'h22] = 8'h5A;
      mem_arr[8'hFE] = 8'hDC; mem_arr[8'hFF] = 8'hEE;

      test_reset();
      test_if_read();
      test_store();
      test_priority();
      test_wrap();
      test_reset_mid();
      test_ignored();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
